// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared types and constants for the Montgomery / modular multiplier
package mont_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CORRECT = 2'd2,
    ST_FINISH  = 2'd3
  } state_e;

  localparam logic MODE_MONT   = 1'b0;
  localparam logic MODE_MODMUL = 1'b1;

  // Counter must hold values 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mont_iter.sv
// rtl/mont_iter.sv - one combinational bit-serial iteration of either multiply mode
module mont_iter
  import mont_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH+1:0] acc_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic             abit_i,
  input  logic             mode_i,
  output logic [WIDTH+1:0] acc_o
);

  logic [WIDTH+1:0] b_ext;
  logic [WIDTH+1:0] n_ext;
  logic [WIDTH+1:0] t;

  assign b_ext = {2'b00, b_i};
  assign n_ext = {2'b00, n_i};

  // Montgomery: add, make even with n, halve. Modmul: double-and-add with two reductions.
  always_comb begin
    t     = '0;
    acc_o = '0;
    if (mode_i == MODE_MONT) begin
      t = acc_i + (abit_i ? b_ext : '0);
      if (t[0]) begin
        t = t + n_ext;
      end
      acc_o = t >> 1;
    end else begin
      t = {acc_i[WIDTH:0], 1'b0};
      if (t >= n_ext) begin
        t = t - n_ext;
      end
      if (abit_i) begin
        t = t + b_ext;
      end
      if (t >= n_ext) begin
        t = t - n_ext;
      end
      acc_o = t;
    end
  end

endmodule

// File: rtl/mont_mult_param.sv
// rtl/mont_mult_param.sv - bit-serial Montgomery / plain modular multiplier with start/ready/done
module mont_mult_param
  import mont_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             mode_q, mode_d;
  logic             bad_q, bad_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] bit_idx;
  logic             abit;
  logic [WIDTH+1:0] acc_next;
  logic [WIDTH+1:0] acc_corr;
  logic             n_invalid;

  // Montgomery consumes a LSB-first, plain modmul consumes it MSB-first
  assign bit_idx = (mode_q == MODE_MODMUL) ? (CNT_W'(WIDTH - 1) - cnt_q) : cnt_q;
  assign abit    = a_q[bit_idx];

  assign n_invalid = (n == '0) || ((mode == MODE_MONT) && !n[0]);

  mont_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .acc_i (acc_q),
    .b_i   (b_q),
    .n_i   (n_q),
    .abit_i(abit),
    .mode_i(mode_q),
    .acc_o (acc_next)
  );

  assign acc_corr = (acc_q >= {2'b00, n_q}) ? (acc_q - {2'b00, n_q}) : acc_q;

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      mode_q  <= MODE_MONT;
      bad_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      bad_q   <= bad_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; an invalid modulus still walks through CORRECT so that
  // both paths see the same CORRECT -> FINISH -> done timing.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    mode_d  = mode_q;
    bad_d   = bad_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          n_d    = n;
          mode_d = mode;
          acc_d  = '0;
          cnt_d  = '0;
          bad_d  = n_invalid;
          state_d = n_invalid ? ST_CORRECT : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_CORRECT;
        end
      end
      ST_CORRECT: begin
        if (bad_q) begin
          out_d = '0;
          err_d = 1'b1;
        end else begin
          out_d = acc_corr[WIDTH-1:0];
          err_d = 1'b0;
        end
        state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign out   = out_q;

endmodule

// File: tb/tb_mont_mult_param.sv
// tb/tb_mont_mult_param.sv - directed self-checking bench for mont_mult_param at WIDTH=8
module tb_mont_mult_param;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] n;
  logic         ready;
  logic         done;
  logic         err;
  logic [W-1:0] out;

  int errors = 0;
  int checks = 0;

  mont_mult_param #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mode (mode),
    .a    (a),
    .b    (b),
    .n    (n),
    .ready(ready),
    .done (done),
    .err  (err),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for ready (bounded), present operands, accept on one edge, then scramble inputs
  task automatic start_op(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] nv);
    int guard;
    guard = 0;
    while (!ready && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    mode  = m;
    a     = av;
    b     = bv;
    n     = nv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    n     = nv + 8'd2;
    mode  = ~m;
  endtask

  // Count edges until done is seen high; 999 means the bound expired
  task automatic wait_done(input int pre, output int lat, output logic rdy_low);
    logic seen;
    lat     = pre;
    rdy_low = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (ready) rdy_low = 1'b0;
    end
    if (!seen) lat = 999;
  endtask

  task automatic run_op(input string tag, input logic m, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] nv,
                        input logic [W-1:0] exp_out, input logic exp_err, input int exp_lat);
    int   lat;
    logic rl;
    start_op(m, av, bv, nv);
    wait_done(0, lat, rl);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdy_low"}, {31'd0, rl}, 32'd1);
    check({tag, "_out"}, {24'd0, out}, {24'd0, exp_out});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int   lat;
    int   lat2;
    logic rl;

    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    a     = '0;
    b     = '0;
    n     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_out", {24'd0, out}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("m0_5x7", 1'b0, 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 10);
    run_op("m1_5x7", 1'b1, 8'd5, 8'd7, 8'd13, 8'd9, 1'b0, 10);
    run_op("m1_12x12", 1'b1, 8'd12, 8'd12, 8'd13, 8'd1, 1'b0, 10);
    run_op("m0_12x12", 1'b0, 8'd12, 8'd12, 8'd13, 8'd3, 1'b0, 10);
    run_op("m0_even_n", 1'b0, 8'd5, 8'd7, 8'd12, 8'd0, 1'b1, 2);
    run_op("m0_after_err", 1'b0, 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 10);
    run_op("m1_200x150", 1'b1, 8'd200, 8'd150, 8'd251, 8'd131, 1'b0, 10);
    run_op("m0_200x150", 1'b0, 8'd200, 8'd150, 8'd251, 8'd227, 1'b0, 10);
    run_op("m0_254x254", 1'b0, 8'd254, 8'd254, 8'd255, 8'd1, 1'b0, 10);
    run_op("m1_254x254", 1'b1, 8'd254, 8'd254, 8'd255, 8'd1, 1'b0, 10);
    run_op("m0_a_zero", 1'b0, 8'd0, 8'd7, 8'd13, 8'd0, 1'b0, 10);
    run_op("m1_b_zero", 1'b1, 8'd9, 8'd0, 8'd13, 8'd0, 1'b0, 10);
    run_op("m1_n_zero", 1'b1, 8'd5, 8'd7, 8'd0, 8'd0, 1'b1, 2);
    run_op("m1_even_n", 1'b1, 8'd5, 8'd7, 8'd12, 8'd11, 1'b0, 10);

    // start pulsed mid-run with other operands must be ignored
    start_op(1'b0, 8'd5, 8'd7, 8'd13);
    repeat (3) @(posedge clk);
    #1;
    mode  = 1'b1;
    a     = 8'd12;
    b     = 8'd12;
    n     = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midstart_ready", {31'd0, ready}, 32'd0);
    wait_done(4, lat, rl);
    check("midstart_lat", lat, 10);
    check("midstart_rdy_low", {31'd0, rl}, 32'd1);
    check("midstart_out", {24'd0, out}, 32'd1);
    @(posedge clk);
    #1;

    // reset mid-run aborts immediately with no done pulse
    start_op(1'b1, 8'd5, 8'd7, 8'd13);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_out", {24'd0, out}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_done_after", {31'd0, done}, 32'd0);
    run_op("post_rst", 1'b1, 8'd5, 8'd7, 8'd13, 8'd9, 1'b0, 10);

    // start held high: back-to-back ops every WIDTH+3 cycles
    mode  = 1'b1;
    a     = 8'd5;
    b     = 8'd7;
    n     = 8'd13;
    start = 1'b1;
    wait_done(0, lat, rl);
    check("held_first_lat", lat, 11);
    wait_done(0, lat2, rl);
    start = 1'b0;
    check("held_period", lat2, W + 3);
    check("held_out", {24'd0, out}, 32'd9);
    @(posedge clk);
    #1;
    check("held_idle_ready", {31'd0, ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
